// File: rtl/hssl_probe_pkg.sv
// hssl_probe_pkg: word-filter FSM encoding and width helper shared by the probe monitor
package hssl_probe_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} filt_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hssl_probe_monitor_if.sv
// hssl_probe_monitor_if: probe bundle; master = GTH/VIO side (status_in, word_in, clear_in, freeze_in), slave = monitor (conditioned outputs)
interface hssl_probe_monitor_if #(
  parameter int NUM_BITS = 8,
  parameter int WORD_W   = 32,
  parameter int CNT_W    = 16
);
  logic [NUM_BITS-1:0]       status_in, status_sync, sticky_rise, sticky_fall;
  logic [WORD_W-1:0]         word_in, word_snap;
  logic                      clear_in, freeze_in, word_valid;
  logic [NUM_BITS*CNT_W-1:0] toggle_cnt;
  modport master (
    output status_in, word_in, clear_in, freeze_in,
    input  status_sync, sticky_rise, sticky_fall, toggle_cnt, word_snap, word_valid
  );
  modport slave (
    input  status_in, word_in, clear_in, freeze_in,
    output status_sync, sticky_rise, sticky_fall, toggle_cnt, word_snap, word_valid
  );
endinterface

// File: rtl/hssl_probe_sync.sv
// hssl_probe_sync: STAGES-deep single-bit synchroniser; clk/rst (async high), d async in, q synchronised out
module hssl_probe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/hssl_probe_monitor.sv
// hssl_probe_monitor: syncs status/word probes into hsslif_clk (hsslif_reset async high), adds sticky edge flags, saturating toggle counters and a stability-filtered word snapshot on the slave modport bus
module hssl_probe_monitor
  import hssl_probe_pkg::*;
#(
  parameter int NUM_BITS      = 8,
  parameter int WORD_W        = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input logic                hsslif_clk,
  input logic                hsslif_reset,
  hssl_probe_monitor_if.slave bus
);
  localparam int SW = clog2(STABLE_CYCLES + 1);
  logic [NUM_BITS-1:0]       st_sync, prev, rise, fall, ev, rise_f, fall_f;
  logic [WORD_W-1:0]         word_sync, word_sync_q, snap;
  logic [NUM_BITS*CNT_W-1:0] cnt_q;
  logic [SW-1:0]             stab;
  logic                      clear_q, clear_p, changed, due, valid;
  filt_state_t               state;
  for (genvar i = 0; i < NUM_BITS; i++) begin : g_st
    hssl_probe_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(hsslif_clk), .rst(hsslif_reset), .d(bus.status_in[i]), .q(st_sync[i])
    );
  end
  for (genvar i = 0; i < WORD_W; i++) begin : g_wd
    hssl_probe_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(hsslif_clk), .rst(hsslif_reset), .d(bus.word_in[i]), .q(word_sync[i])
    );
  end
  assign rise    = st_sync & ~prev;
  assign fall    = ~st_sync & prev;
  assign ev      = rise | fall;
  assign clear_p = bus.clear_in & ~clear_q;
  assign changed = word_sync != word_sync_q;
  assign due     = stab == SW'(STABLE_CYCLES - 1);
  always_ff @(posedge hsslif_clk or posedge hsslif_reset)
    if (hsslif_reset) begin
      prev    <= '0;
      clear_q <= 1'b0;
      rise_f  <= '0;
      fall_f  <= '0;
      cnt_q   <= '0;
    end else begin
      prev    <= st_sync;
      clear_q <= bus.clear_in;
      if (clear_p) begin
        rise_f <= rise;
        fall_f <= fall;
        for (int j = 0; j < NUM_BITS; j++) cnt_q[j*CNT_W +: CNT_W] <= CNT_W'(ev[j]);
      end else if (!bus.freeze_in) begin
        rise_f <= rise_f | rise;
        fall_f <= fall_f | fall;
        for (int j = 0; j < NUM_BITS; j++)
          if (ev[j] && !(&cnt_q[j*CNT_W +: CNT_W]))
            cnt_q[j*CNT_W +: CNT_W] <= cnt_q[j*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  always_ff @(posedge hsslif_clk or posedge hsslif_reset)
    if (hsslif_reset) begin
      word_sync_q <= '0;
      state       <= IDLE;
      stab        <= '0;
      snap        <= '0;
      valid       <= 1'b0;
    end else begin
      word_sync_q <= word_sync;
      if (clear_p) begin
        state <= SETTLE;
        stab  <= '0;
        valid <= 1'b0;
      end else if (changed) begin
        state <= SETTLE;
        stab  <= '0;
      end else
        case (state)
          IDLE: stab <= due ? stab : stab + SW'(1);
          SETTLE:
            if (!due) stab <= stab + SW'(1);
            else if (!bus.freeze_in) begin
              snap  <= word_sync;
              valid <= 1'b1;
              stab  <= SW'(STABLE_CYCLES);
              state <= HOLD;
            end
          HOLD: state <= HOLD;
          default: state <= IDLE;
        endcase
    end
  assign bus.status_sync = st_sync;
  assign bus.sticky_rise = rise_f;
  assign bus.sticky_fall = fall_f;
  assign bus.toggle_cnt  = cnt_q;
  assign bus.word_snap   = snap;
  assign bus.word_valid  = valid;
endmodule
